// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM state type and default operand width for the modular exponentiator.
package rsa_pkg;
  localparam int RSA_W = 256;
  typedef enum logic [2:0] {IDLE, PREP, MONT, UPD, DONE} rsa_state_t;
endpackage

// File: rtl/rsa_mont_mul.sv
// rsa_mont_mul: bit-serial Montgomery multiplier, o_r = i_x*i_y*2^-WIDTH mod i_n, WIDTH+1 cycle latency.
module rsa_mont_mul #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_r,
  output logic             o_done
);
  localparam int CW = $clog2(WIDTH + 1) + 1;
  logic [WIDTH-1:0] x, y, n;
  logic [WIDTH+1:0] acc, s0, s1;
  logic [CW-1:0] cnt;
  logic run;
  always_comb begin
    s0 = acc + (x[0] ? {2'b0, y} : '0);
    s1 = s0 + (s0[0] ? {2'b0, n} : '0);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x <= '0;
      y <= '0;
      n <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
      o_r <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        x <= i_x;
        y <= i_y;
        n <= i_n;
        acc <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        // acc < 2N after the last iteration, so one subtract lands it below N
        if (cnt == CW'(WIDTH)) begin
          o_r <= acc >= {2'b0, n} ? WIDTH'(acc - {2'b0, n}) : acc[WIDTH-1:0];
          o_done <= 1'b1;
          run <= 1'b0;
        end else begin
          acc <= s1 >> 1;
          x <= x >> 1;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: LSB-first modular exponentiator, o_a_pow_d = i_a^i_d mod i_n for odd i_n.
module rsa_modexp_core import rsa_pkg::*; #(
  parameter int WIDTH     = RSA_W,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [EXP_WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0]     i_n,
  output logic                 o_busy,
  output logic [WIDTH-1:0]     o_a_pow_d,
  output logic                 o_finished
);
  localparam int CW = $clog2(WIDTH + 1) + 1;
  localparam int JW = $clog2(EXP_WIDTH) + 1;
  localparam logic [JW-1:0] J_LAST = JW'(EXP_WIDTH - 1);
  rsa_state_t state;
  logic [WIDTH-1:0] n, t, m, mm, tt, m_nxt, t_nxt;
  logic [EXP_WIDTH-1:0] d;
  logic [CW-1:0] cnt;
  logic [JW-1:0] j;
  logic [WIDTH:0] dbl;
  logic mm_done, tt_done, go;
  // m stays in the normal domain while t carries a^(2^j) in Montgomery form,
  // so mont(m,t) multiplies in plain a^(2^j) and no final conversion is needed.
  always_comb begin
    dbl = {t, 1'b0};
    m_nxt = (state == UPD && d[0]) ? mm : m;
    t_nxt = state == UPD ? tt : t;
    go = (state == PREP && cnt == CW'(WIDTH)) || (state == UPD && mm_done && tt_done && j != J_LAST);
  end
  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(go), .i_x(m_nxt), .i_y(t_nxt), .i_n(n),
    .o_r(mm), .o_done(mm_done)
  );
  rsa_mont_mul #(.WIDTH(WIDTH)) u_sqr (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(go), .i_x(t_nxt), .i_y(t_nxt), .i_n(n),
    .o_r(tt), .o_done(tt_done)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_busy <= 1'b0;
      o_finished <= 1'b0;
      o_a_pow_d <= '0;
      n <= '0;
      t <= '0;
      m <= '0;
      d <= '0;
      cnt <= '0;
      j <= '0;
    end else begin
      o_finished <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          t <= i_a;
          d <= i_d;
          n <= i_n;
          m <= WIDTH'(1);
          cnt <= '0;
          j <= '0;
          o_busy <= 1'b1;
          state <= PREP;
        end
        PREP: begin
          if (cnt == CW'(WIDTH)) begin
            cnt <= '0;
            state <= MONT;
          end else begin
            t <= dbl >= {1'b0, n} ? WIDTH'(dbl - {1'b0, n}) : dbl[WIDTH-1:0];
            cnt <= cnt + 1'b1;
          end
        end
        MONT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) state <= UPD;
        end
        UPD: if (mm_done && tt_done) begin
          t <= t_nxt;
          m <= m_nxt;
          d <= d >> 1;
          j <= j + 1'b1;
          cnt <= '0;
          state <= j == J_LAST ? DONE : MONT;
        end
        DONE: begin
          o_finished <= 1'b1;
          o_a_pow_d <= m;
          o_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: directed checks on an 8-bit core plus random 256-bit runs against a software model.
module tb_rsa_modexp_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, busy, fin;
  logic [7:0] a, d, n, res;
  logic w_start, w_busy, w_fin;
  logic [255:0] w_a, w_n, w_res;
  logic [15:0] w_d;
  int tests = 0, fails = 0;

  rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_d(d), .i_n(n),
    .o_busy(busy), .o_a_pow_d(res), .o_finished(fin)
  );
  rsa_modexp_core #(.WIDTH(256), .EXP_WIDTH(16)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_start(w_start), .i_a(w_a), .i_d(w_d), .i_n(w_n),
    .o_busy(w_busy), .o_a_pow_d(w_res), .o_finished(w_fin)
  );

  function automatic logic [255:0] ref_modexp(logic [255:0] av, logic [15:0] dv, logic [255:0] nv);
    logic [511:0] r, b, nn;
    r = 512'd1;
    b = {256'd0, av};
    nn = {256'd0, nv};
    for (int i = 0; i < 16; i++) begin
      if (dv[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[255:0];
  endfunction

  task automatic run8(input logic [7:0] av, dv, nv, exp_r, input string name);
    int cyc;
    bit drop;
    a = av; d = dv; n = nv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_after_accept got=%b want=1", name, busy); end
    cyc = 0;
    drop = 0;
    while (fin !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (fin !== 1'b1 && busy !== 1'b1) drop = 1;
    end
    tests++;
    if (cyc !== 90) begin fails++; $display("FAIL %s latency got=%0d want=90", name, cyc); end
    tests++;
    if (res !== exp_r) begin fails++; $display("FAIL %s result got=%0d want=%0d", name, res, exp_r); end
    tests++;
    if (drop || busy !== 1'b0) begin fails++; $display("FAIL %s busy_profile dropped=%0d end_busy=%b want 0/0", name, drop, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 8'd88; d = 8'd7; n = 8'd187;
    w_start = 1'b0; w_a = '0; w_d = '0; w_n = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || fin !== 1'b0 || res !== 8'd0) begin
      fails++; $display("FAIL reset_state busy=%b fin=%b res=%0d want 0/0/0", busy, fin, res);
    end
    tests++;
    if (w_busy !== 1'b0 || w_fin !== 1'b0 || w_res !== '0) begin
      fails++; $display("FAIL reset_state_wide busy=%b fin=%b want 0/0 res_zero=%b", w_busy, w_fin, w_res == '0);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run8(8'd88, 8'd7, 8'd187, 8'd11, "basic_88_7");
  endtask

  task automatic test_back_to_back;
    run8(8'd11, 8'd23, 8'd187, 8'd88, "b2b_first");
    run8(8'd88, 8'd7, 8'd187, 8'd11, "b2b_second");
  endtask

  task automatic test_boundaries;
    run8(8'd5, 8'd0, 8'd187, 8'd1, "d_zero");
    @(posedge clk); #1;
    tests++;
    if (fin !== 1'b0) begin fails++; $display("FAIL finished_pulse_width got=%b want=0", fin); end
    run8(8'd0, 8'd5, 8'd187, 8'd0, "a_zero");
    run8(8'd186, 8'd2, 8'd187, 8'd1, "a_n_minus_1");
  endtask

  task automatic test_ignore_start;
    int cyc;
    bit drop;
    a = 8'd88; d = 8'd7; n = 8'd187; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    drop = 0;
    repeat (20) begin @(posedge clk); #1; cyc++; if (busy !== 1'b1) drop = 1; end
    a = 8'd11; d = 8'd23; start = 1'b1;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    while (fin !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (fin !== 1'b1 && busy !== 1'b1) drop = 1;
    end
    tests++;
    if (cyc !== 90) begin fails++; $display("FAIL ignore_start latency got=%0d want=90", cyc); end
    tests++;
    if (res !== 8'd11) begin fails++; $display("FAIL ignore_start result got=%0d want=11", res); end
    tests++;
    if (drop) begin fails++; $display("FAIL ignore_start busy dropped got=1 want=0"); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    a = 8'd11; d = 8'd23; n = 8'd187; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || res !== 8'd0 || fin !== 1'b0) begin
      fails++; $display("FAIL reset_mid state busy=%b res=%0d fin=%b want 0/0/0", busy, res, fin);
    end
    seen = 0;
    repeat (120) begin @(posedge clk); #1; if (fin !== 1'b0 || busy !== 1'b0) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL reset_mid activity after reset got=1 want=0"); end
    run8(8'd88, 8'd7, 8'd187, 8'd11, "after_reset");
  endtask

  task automatic test_random_wide;
    logic [255:0] ra, exp_r;
    int cyc;
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 8; k++) begin
        w_n[32*k +: 32] = $urandom;
        ra[32*k +: 32] = $urandom;
      end
      w_n[255] = 1'b1;
      w_n[0] = 1'b1;
      w_a = ra % w_n;
      w_d = 16'($urandom_range(0, 65535));
      exp_r = ref_modexp(w_a, w_d, w_n);
      w_start = 1'b1;
      @(posedge clk); #1;
      w_start = 1'b0;
      cyc = 0;
      while (w_fin !== 1'b1 && cyc < 6000) begin @(posedge clk); #1; cyc++; end
      tests++;
      if (cyc !== 4386) begin fails++; $display("FAIL wide_latency run=%0d got=%0d want=4386", it, cyc); end
      tests++;
      if (w_res !== exp_r) begin fails++; $display("FAIL wide_result run=%0d got=%h want=%h", it, w_res, exp_r); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_boundaries;
    test_ignore_start;
    test_reset_mid;
    test_random_wide;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
